// File: rtl/instr_decd_pkg.sv
// Types and constants shared by the instruction-address generator and the
// round-robin arbiter that is also reused by the data-memory path.
package instr_decd_pkg;
   localparam int   ADDR_W_DEF  = 16;
   localparam int   NUM_CH_DEF  = 4;
   localparam logic RESET_STATE = 1'b0;

   typedef logic [ADDR_W_DEF-1:0]         instr_addr_t;
   typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_id_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ch_state_e;

   // Width of a channel index; a single channel still gets one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/instr_mem_addr_gen_mc_rr_arbiter.sv
// Round-robin arbiter: N requests -> one-hot grant, search starts at the
// pointer, pointer moves past the winner and holds when nothing is granted.
module rr_arbiter import instr_decd_pkg::*; #(
   parameter  int N    = 4,
   localparam int ID_W = id_w(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic            gnt_vld,
   output logic [ID_W-1:0] gnt_id
);
   logic [ID_W-1:0] ptr_q, ptr_d;
   int idx;

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr_q) + i) % N;
         if (!gnt_vld && req[idx]) begin
            gnt_vld  = 1'b1;
            gnt_id   = ID_W'(idx);
            gnt[idx] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (gnt_vld) ptr_d = ID_W'((int'(gnt_id) + 1) % N);
   end

   always_ff @(posedge clk) begin
      if (rst == RESET_STATE) ptr_q <= '0;
      else                    ptr_q <= ptr_d;
   end
endmodule

// File: rtl/instr_mem_addr_gen_mc.sv
// Multi-channel instruction-memory address generator with credit gating and a
// read-latency tag pipe. Define INSTR_ADDR_GEN_LOOP_EN for per-channel looping.
module instr_mem_addr_gen_mc import instr_decd_pkg::*; #(
   parameter  int NUM_CH     = 4,
   parameter  int ADDR_W     = 16,
   parameter  int RD_LATENCY = 2,
   parameter  int CREDITS    = 4,
   localparam int CH_W       = id_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        start,
   input  logic [NUM_CH*ADDR_W-1:0] base_addr,
   input  logic [NUM_CH*ADDR_W-1:0] len,
`ifdef INSTR_ADDR_GEN_LOOP_EN
   input  logic [NUM_CH-1:0]        loop_en,
`endif
   input  logic [NUM_CH-1:0]        fetcher_consume,
   output logic [ADDR_W-1:0]        instr_mem_rd_addr,
   output logic                     instr_mem_rd_en,
   output logic [NUM_CH-1:0]        rd_vld_to_fetcher,
   output logic [CH_W-1:0]          rd_ch_id,
   output logic [NUM_CH-1:0]        ch_busy,
   output logic [NUM_CH-1:0]        ch_done
);
   localparam int CRED_W = $clog2(CREDITS + 1);
   localparam int EXIT   = RD_LATENCY - 1;

   ch_state_e                       st_q [NUM_CH];
   ch_state_e                       st_d [NUM_CH];
   logic [NUM_CH-1:0][ADDR_W-1:0]   cur_q, cur_d, rem_q, rem_d;
   logic [NUM_CH-1:0][CRED_W-1:0]   cred_q, cred_d;
`ifdef INSTR_ADDR_GEN_LOOP_EN
   logic [NUM_CH-1:0][ADDR_W-1:0]   base_q, base_d, len_q, len_d;
   logic [NUM_CH-1:0]               loop_q, loop_d;
`endif
   logic [NUM_CH-1:0]               req, gnt, exit_last, last_pend;
   logic                            gnt_vld;
   logic [CH_W-1:0]                 gnt_id;
   logic [RD_LATENCY-1:0]           vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
   logic [RD_LATENCY-1:0][CH_W-1:0] id_pipe_q, id_pipe_d;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++)
         req[c] = (st_q[c] == RUN) && (rem_q[c] != '0) && (cred_q[c] != '0);
   end

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   assign instr_mem_rd_en   = gnt_vld;
   assign instr_mem_rd_addr = gnt_vld ? cur_q[gnt_id] : '0;

   // Each tag remembers whether it closes a pass so ch_done lines up with data.
   always_comb begin
      vld_pipe_d  = vld_pipe_q;
      id_pipe_d   = id_pipe_q;
      last_pipe_d = last_pipe_q;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
         vld_pipe_d[i]  = vld_pipe_q[i-1];
         id_pipe_d[i]   = id_pipe_q[i-1];
         last_pipe_d[i] = last_pipe_q[i-1];
      end
      vld_pipe_d[0]  = gnt_vld;
      id_pipe_d[0]   = gnt_vld ? gnt_id : '0;
      last_pipe_d[0] = gnt_vld && (rem_q[gnt_id] == ADDR_W'(1));
   end

   always_comb begin
      rd_ch_id = id_pipe_q[EXIT];
      for (int c = 0; c < NUM_CH; c++) begin
         rd_vld_to_fetcher[c] = vld_pipe_q[EXIT] && (id_pipe_q[EXIT] == CH_W'(c));
         exit_last[c]         = rd_vld_to_fetcher[c] && last_pipe_q[EXIT];
         last_pend[c]         = 1'b0;
         for (int i = 0; i < EXIT; i++)
            if (vld_pipe_q[i] && last_pipe_q[i] && (id_pipe_q[i] == CH_W'(c)))
               last_pend[c] = 1'b1;
         ch_busy[c] = (st_q[c] == RUN) || (st_q[c] == DRAIN);
         ch_done[c] = (st_q[c] == DONE) || exit_last[c];
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         st_d[c]   = st_q[c];
         cur_d[c]  = cur_q[c];
         rem_d[c]  = rem_q[c];
         cred_d[c] = cred_q[c];
`ifdef INSTR_ADDR_GEN_LOOP_EN
         base_d[c] = base_q[c];
         len_d[c]  = len_q[c];
         loop_d[c] = loop_q[c];
`endif
         case (st_q[c])
            IDLE: if (start[c]) begin
               if (len[c*ADDR_W +: ADDR_W] == '0) begin
                  st_d[c] = DONE;
               end else begin
                  st_d[c]  = RUN;
                  cur_d[c] = base_addr[c*ADDR_W +: ADDR_W];
                  rem_d[c] = len[c*ADDR_W +: ADDR_W];
`ifdef INSTR_ADDR_GEN_LOOP_EN
                  base_d[c] = base_addr[c*ADDR_W +: ADDR_W];
                  len_d[c]  = len[c*ADDR_W +: ADDR_W];
                  loop_d[c] = loop_en[c];
`endif
               end
            end
            RUN: if (gnt[c]) begin
               cur_d[c] = cur_q[c] + ADDR_W'(1);
               rem_d[c] = rem_q[c] - ADDR_W'(1);
               if (rem_q[c] == ADDR_W'(1)) begin
`ifdef INSTR_ADDR_GEN_LOOP_EN
                  if (loop_q[c] && loop_en[c]) begin
                     cur_d[c] = base_q[c];
                     rem_d[c] = len_q[c];
                  end else begin
                     st_d[c] = DRAIN;
                  end
`else
                  st_d[c] = DRAIN;
`endif
               end
            end
            // An older pass's last tag may still be in flight after looping stops.
            DRAIN: if (exit_last[c] && !last_pend[c]) st_d[c] = IDLE;
            default: st_d[c] = IDLE;
         endcase
         if (gnt[c] && !fetcher_consume[c])
            cred_d[c] = cred_q[c] - CRED_W'(1);
         else if (!gnt[c] && fetcher_consume[c] && (cred_q[c] != CRED_W'(CREDITS)))
            cred_d[c] = cred_q[c] + CRED_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RESET_STATE) begin
         for (int c = 0; c < NUM_CH; c++) st_q[c] <= IDLE;
         cur_q       <= '0;
         rem_q       <= '0;
         cred_q      <= {NUM_CH{CRED_W'(CREDITS)}};
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
         last_pipe_q <= '0;
`ifdef INSTR_ADDR_GEN_LOOP_EN
         base_q      <= '0;
         len_q       <= '0;
         loop_q      <= '0;
`endif
      end else begin
         st_q        <= st_d;
         cur_q       <= cur_d;
         rem_q       <= rem_d;
         cred_q      <= cred_d;
         vld_pipe_q  <= vld_pipe_d;
         id_pipe_q   <= id_pipe_d;
         last_pipe_q <= last_pipe_d;
`ifdef INSTR_ADDR_GEN_LOOP_EN
         base_q      <= base_d;
         len_q       <= len_d;
         loop_q      <= loop_d;
`endif
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++)
         if ((rst != RESET_STATE) && fetcher_consume[c] && !gnt[c] &&
             (cred_q[c] == CRED_W'(CREDITS)))
            $error("credit overflow on channel %0d", c);
   end
`endif
endmodule

// File: tb/tb_instr_mem_addr_gen_mc.sv
// Directed + random bench for instr_mem_addr_gen_mc; a cycle-level reference
// model predicts issues, returns, busy and done from the stream rules.
module tb_instr_mem_addr_gen_mc;
   import instr_decd_pkg::*;
   localparam int NUM_CH = 4, ADDR_W = 16, RD_LATENCY = 2, CREDITS = 4, CH_W = 2;
   localparam int MAXC = 4096;

   logic clk = 1'b0, rst = 1'b0;
   logic [NUM_CH-1:0]        start, fetcher_consume, loop_en;
   logic [NUM_CH*ADDR_W-1:0] base_addr, len;
   logic [ADDR_W-1:0]        instr_mem_rd_addr;
   logic                     instr_mem_rd_en;
   logic [NUM_CH-1:0]        rd_vld_to_fetcher, ch_busy, ch_done;
   logic [CH_W-1:0]          rd_ch_id;

   always #5 clk = ~clk;

   instr_mem_addr_gen_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W),
                           .RD_LATENCY(RD_LATENCY), .CREDITS(CREDITS)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .base_addr         (base_addr),
      .len               (len),
`ifdef INSTR_ADDR_GEN_LOOP_EN
      .loop_en           (loop_en),
`endif
      .fetcher_consume   (fetcher_consume),
      .instr_mem_rd_addr (instr_mem_rd_addr),
      .instr_mem_rd_en   (instr_mem_rd_en),
      .rd_vld_to_fetcher (rd_vld_to_fetcher),
      .rd_ch_id          (rd_ch_id),
      .ch_busy           (ch_busy),
      .ch_done           (ch_done)
   );

   int checks = 0, failures = 0, cyc = 0, issues = 0;
   int cons_mode = 0;
   logic [NUM_CH-1:0] force_cons = '0;
   int iss_q[$];

   // reference model state
   bit m_run[NUM_CH], m_loop[NUM_CH];
   int m_cur[NUM_CH], m_rem[NUM_CH], m_cred[NUM_CH], m_base[NUM_CH], m_len[NUM_CH];
   int m_drain_end[NUM_CH], m_done0[NUM_CH], m_ptr;
   bit r_vld[MAXC], r_last[MAXC];
   int r_ch[MAXC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_run[c] = 0; m_loop[c] = 0; m_cred[c] = CREDITS;
         m_drain_end[c] = -1; m_done0[c] = -1;
      end
      m_ptr = 0;
      for (int i = cyc + 1; i <= cyc + RD_LATENCY && i < MAXC; i++) r_vld[i] = 0;
   endfunction

   function automatic bit m_idle(input int c);
      return !m_run[c] && (m_drain_end[c] < cyc) && (m_done0[c] != cyc);
   endfunction

   task automatic set_ch(input int c, input int b, input int l);
      base_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(b);
      len[c*ADDR_W +: ADDR_W]       = ADDR_W'(l);
   endtask

   // One clock: predict, compare at negedge, advance model, then the edge.
   task automatic step(input bit do_chk);
      int g, e_ch, t;
      bit e_vld;
      logic [NUM_CH-1:0] e_done, e_busy, e_rvld;
      for (int c = 0; c < NUM_CH; c++)
         fetcher_consume[c] = ((cons_mode == 1) || (cons_mode == 2 && $urandom_range(1) == 1) ||
                               force_cons[c]) && (m_cred[c] < CREDITS);
      @(negedge clk);
      g = -1;
      for (int i = 0; i < NUM_CH; i++) begin
         int c = (m_ptr + i) % NUM_CH;
         if (g < 0 && m_run[c] && m_cred[c] > 0) g = c;
      end
      e_vld = r_vld[cyc];
      e_ch  = e_vld ? r_ch[cyc] : 0;
      for (int c = 0; c < NUM_CH; c++) begin
         e_rvld[c] = e_vld && (e_ch == c);
         e_done[c] = (e_vld && e_ch == c && r_last[cyc]) || (m_done0[c] == cyc);
         e_busy[c] = m_run[c] || (m_drain_end[c] >= cyc);
      end
      if (do_chk) begin
         chk("rd_en",    32'(instr_mem_rd_en),   32'(g >= 0));
         chk("rd_addr",  32'(instr_mem_rd_addr), (g >= 0) ? m_cur[g] : 0);
         chk("rd_vld",   32'(rd_vld_to_fetcher), 32'(e_rvld));
         chk("rd_ch_id", 32'(rd_ch_id),          e_ch);
         chk("ch_done",  32'(ch_done),           32'(e_done));
         chk("ch_busy",  32'(ch_busy),           32'(e_busy));
      end
      if (instr_mem_rd_en === 1'b1) begin
         issues++;
         iss_q.push_back(int'(instr_mem_rd_addr));
      end
      if (rst == 1'b0) begin
         m_reset();
      end else begin
         if (g >= 0) begin
            t = cyc + RD_LATENCY;
            r_vld[t] = 1; r_ch[t] = g; r_last[t] = (m_rem[g] == 1);
            m_cur[g] = (m_cur[g] + 1) % 65536;
            m_rem[g]--; m_cred[g]--;
            if (m_rem[g] == 0) begin
               if (m_loop[g] && loop_en[g]) begin
                  m_cur[g] = m_base[g]; m_rem[g] = m_len[g];
               end else begin
                  m_run[g] = 0; m_drain_end[g] = t;
               end
            end
            m_ptr = (g + 1) % NUM_CH;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (fetcher_consume[c]) m_cred[c]++;
            if (start[c] && m_idle(c)) begin
               if (len[c*ADDR_W +: ADDR_W] == '0) m_done0[c] = cyc + 1;
               else begin
                  m_run[c]  = 1;
                  m_base[c] = int'(base_addr[c*ADDR_W +: ADDR_W]);
                  m_len[c]  = int'(len[c*ADDR_W +: ADDR_W]);
                  m_cur[c]  = m_base[c];
                  m_rem[c]  = m_len[c];
                  m_loop[c] = loop_en[c];
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      start = '0;
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b1);
   endtask

   initial begin
      start = '0; base_addr = '0; len = '0; loop_en = '0; fetcher_consume = '0;
      m_reset();
      // reset, then idle outputs
      rst = 1'b0; step(1'b0); step(1'b0); rst = 1'b1;
      run(2);

      // single channel, consume whenever possible
      cons_mode = 1; iss_q.delete();
      set_ch(0, 'h10, 3); start = 4'b0001; run(8);
      chk("single_cnt", iss_q.size(), 3);
      for (int i = 0; i < 3 && i < iss_q.size(); i++) chk("single_addr", iss_q[i], 'h10 + i);

      // credit stall: no consume, then a single consume pulse
      cons_mode = 0; issues = 0;
      set_ch(1, 'h200, 7); start = 4'b0010; run(12);
      chk("stall_issues", issues, CREDITS);
      issues = 0; force_cons = 4'b0010; step(1'b1); force_cons = '0; run(8);
      chk("one_more_issue", issues, 1);
      cons_mode = 1; run(12);

      // four channels together from a fresh pointer
      rst = 1'b0; step(1'b1); rst = 1'b1;
      iss_q.delete();
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 'h1000 + c * 'h100, 2);
      start = '1; run(14);
      chk("rr_cnt", iss_q.size(), 8);
      for (int i = 0; i < 8 && i < iss_q.size(); i++)
         chk("rr_order", iss_q[i], 'h1000 + (i % 4) * 'h100 + i / 4);

      // address wrap
      iss_q.delete();
      set_ch(3, 'hFFFE, 4); start = 4'b1000; run(10);
      chk("wrap_cnt", iss_q.size(), 4);
      for (int i = 0; i < 4 && i < iss_q.size(); i++) chk("wrap_addr", iss_q[i], ('hFFFE + i) % 65536);

      // len==0 start, then a start during RUN that must be ignored
      iss_q.delete();
      set_ch(2, 'h40, 0); start = 4'b0100; run(4);
      chk("len0_no_rd", iss_q.size(), 0);
      set_ch(2, 'h50, 4); start = 4'b0100; run(2);
      set_ch(2, 'h900, 3); start = 4'b0100; run(10);
      chk("ignore_cnt", iss_q.size(), 4);
      for (int i = 0; i < 4 && i < iss_q.size(); i++) chk("ignore_addr", iss_q[i], 'h50 + i);

      // random traffic
      cons_mode = 2;
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NUM_CH; c++)
            set_ch(c, $urandom_range(65535), $urandom_range(6));
         start = NUM_CH'($urandom_range(15) & $urandom_range(15) & $urandom_range(15));
         step(1'b1);
      end
      cons_mode = 1; run(30);

      // reset mid-stream with tags in flight
      set_ch(0, 'h300, 8); start = 4'b0001; run(4);
      rst = 1'b0; step(1'b1); rst = 1'b1;
      issues = 0; run(5);
      chk("post_rst_rd", issues, 0);

`ifdef INSTR_ADDR_GEN_LOOP_EN
      iss_q.delete();
      loop_en = 4'b0010;
      set_ch(1, 'h80, 2); start = 4'b0010; run(12);
      loop_en = '0; run(10);
      for (int i = 0; i < 6 && i < iss_q.size(); i++) chk("loop_addr", iss_q[i], 'h80 + (i % 2));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_mem_addr_gen_mc.md
Name: instr_mem_addr_gen_mc

Overview:
- Multi-channel successor to the single-stream instruction address generator. It serves NUM_CH independent instruction streams, one per PE group, that share one instruction-memory read port.
- Each channel walks its own address window [base, base+len) and is granted the port by round-robin arbitration. Reads are issued only while the channel's fetcher holds buffer credit.
- A read-latency tag pipeline returns a valid and channel id to the fetchers, aligned with read data.
- Sits between the host/config block and the instr_fetcher array.

Parameters:
- NUM_CH, 4, number of instruction streams (≥1).
- ADDR_W, 16, instruction-memory address width.
- RD_LATENCY, 2, memory read latency in cycles (≥1).
- CREDITS, 4, per-channel fetcher buffer depth (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-low.
- start  in  NUM_CH  per-channel start pulse; samples base/len of that channel.
- base_addr  in  NUM_CH*ADDR_W  per-channel window start.
- len  in  NUM_CH*ADDR_W  per-channel instruction count; 0 means finish immediately.
- fetcher_consume  in  NUM_CH  per-channel pulse: fetcher freed one buffer slot.
- instr_mem_rd_addr  out  ADDR_W  read address.
- instr_mem_rd_en  out  1  read strobe.
- rd_vld_to_fetcher  out  NUM_CH  one-hot: data for that channel appears this cycle.
- rd_ch_id  out  clog2(NUM_CH) (min 1)  channel of returned data.
- ch_busy  out  NUM_CH  channel in RUN or DRAIN.
- ch_done  out  NUM_CH  one-cycle pulse when the last read of a channel returns.

Behaviour:
- Reset (rst==0 at clk edge): all channels IDLE, counters 0, credits=CREDITS, tag pipe cleared, round-robin pointer=0. All outputs 0.
- Per-channel FSM:
  - IDLE→RUN on start with len≠0. Latches cur=base, rem=len.
  - IDLE→DONE (1 cycle, ch_done pulse) on start with len==0.
  - RUN: eligible when rem≠0 and credit≠0. When granted: issue cur, cur←cur+1 (mod 2^ADDR_W, wraps silently), rem←rem-1, credit←credit-1.
  - RUN→DRAIN when the last read issues (rem becomes 0).
  - DRAIN→IDLE when that channel's last tag exits the pipe; ch_done pulses in that same cycle.
  - start while RUN/DRAIN is ignored.
- Credits:
  - Issue and consume in the same cycle leave the credit unchanged.
  - Consume at credit==CREDITS is ignored; sim-only $error.
- Arbitration: one grant per cycle among eligible channels. Round-robin starts at pointer; pointer←granted+1 after each grant, held when no grant.
- Port outputs: instr_mem_rd_en=1 iff a grant exists. instr_mem_rd_addr=granted cur when enabled, else 0. Both are combinational from registered state (zero-cycle issue).
- Tag pipe: RD_LATENCY stages of {vld, ch_id}. It shifts every cycle and has no stall path; backpressure is handled solely by credits. rd_vld_to_fetcher and rd_ch_id appear exactly RD_LATENCY cycles after rd_en.
- Reset mid-operation: everything aborts to reset values; no ch_done is emitted.

Optional Feature:
- INSTR_ADDR_GEN_LOOP_EN defined:
  - Adds input loop_en[NUM_CH], sampled at start.
  - A looping channel reaching rem==0 reloads cur=base, rem=len and stays RUN indefinitely.
  - ch_done pulses at each wrap, when the last tag of each pass returns.
  - Deasserting loop_en ends the current pass normally.
- Undefined: the port is absent; channels always end after one pass.

Decomposition:
- Package instr_decd_pkg gains:
  - typedefs instr_addr_t (ADDR_W) and ch_id_t;
  - the ch_state_e enum (IDLE, RUN, DRAIN, DONE);
  - RESET_STATE=1'b0.
- Sub-module rr_arbiter (NUM_CH requests → one-hot grant, pointer update). It is reused by the data-memory path.

Test Plan:
- Single channel, base=0x10, len=3, fetcher consumes every cycle, RD_LATENCY=2 → addresses 0x10,0x11,0x12 on consecutive cycles; vld at issue+2; ch_done one cycle after the last vld... precisely in the cycle the 3rd vld returns.
- Credit stall, CREDITS=2, no consume, len=5 → exactly 2 reads issue. One consume pulse → exactly one more read. rd_en otherwise low.
- Four channels start together, len=2 each → grant order ch0,1,2,3,0,1,2,3. rd_ch_id follows the same order, delayed by RD_LATENCY.
- base=0xFFFE, len=4, ADDR_W=16 → addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- len=0 start → ch_done next cycle, no rd_en. Start during RUN → ignored, address sequence unchanged.
- rst low mid-stream with 2 tags in flight → next cycle all outputs 0 and no vld emerges. With LOOP_EN, len=2 → sequence base,base+1,base,base+1… with ch_done per pass.
